memory_io_controller: RTL and testbench
=======================================

Name: memory_io_controller

Overview:
- Memory/I-O stage directly downstream of the eLC-3 datapath.
- Takes MAR, MDR, MIO_EN and R_W from the datapath and control FSM, and performs a multi-cycle access to external asynchronous SRAM or to the memory-mapped device registers (KBSR/KBDR/DSR/DDR).
- Returns read data on In to the datapath's MDR mux and pulses R (ready) to the control FSM.

Parameters:
WAIT_STATES, 2, SRAM cycles with strobes asserted before data capture / write completion (valid range 1..15)
SRAM_AW, 20, external SRAM address width; MAR zero-extended into it

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
MAR  in  16  access address
MDR  in  16  write data (datapath Out)
MIO_EN  in  1  access request, held by the control FSM until R is seen
R_W  in  1  1 = write, 0 = read; sampled with MIO_EN
In  out  16  read data to the MDR mux, registered
R  out  1  access complete, one-cycle pulse
SRAM_ADDR  out  SRAM_AW  SRAM address
SRAM_WDATA  out  16  SRAM write data
SRAM_RDATA  in  16  SRAM read data
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low strobes
KeyValid  in  1  one-cycle pulse: new keyboard character
KeyData  in  8  character accompanying KeyValid
DispData  out  8  character to display
DispValid  out  1  display data pending
DispReady  in  1  display accepts DispData when DispValid & DispReady
KbdIntReq  out  1  KBSR[15] & KBSR[14]

Behaviour:
- Reset asserted (async): FSM=IDLE; R=0; In=0; SRAM strobes=1; SRAM_ADDR=0; SRAM_WDATA=0; KBSR=0; KBDR=0; DispValid=0; DispData=0; DSR[15]=1. An access in flight is abandoned and never completes.
- Address decode: xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR.
  - Any other address in xFE00..xFFFF is unmapped: reads return 0, writes are ignored.
  - Below xFE00 goes to SRAM.
- FSM states: IDLE, SRAM_ACC, DONE.
- IDLE, MIO_EN=1 at edge T: latch MAR, MDR and R_W.
  - Device register target: perform the access at edge T and enter DONE.
  - SRAM target: drive SRAM_ADDR, CE_N=0, and either OE_N=0 (read) or WE_N=0 with SRAM_WDATA=MDR (write); enter SRAM_ACC.
- SRAM_ACC: lasts exactly WAIT_STATES cycles, counted by an internal counter.
  - At the final edge, a read captures SRAM_RDATA into In.
  - All strobes return to 1 on entry to DONE. Address and data stay stable while WE_N=0.
- DONE: R=1 for exactly one cycle, then IDLE.
- Latency (cycles from the MIO_EN sampling edge to R high):
  - Device register access: R is high in cycle T+1.
  - SRAM access: R is high in cycle T+1+WAIT_STATES.
- MIO_EN still high in the DONE cycle is ignored. MIO_EN high in IDLE always starts a new access.
- In holds its last read value until the next read completes; writes do not change In.
- MIO_EN dropped mid-access: the access still completes and R still pulses.
- KBSR:
  - Bit 15 is the ready flag; bit 14 is interrupt enable (IE).
  - Bits 13..0 read as 0.
  - A write updates only bit 14.
- KeyValid: KBDR[7:0]=KeyData, KBDR[15:8]=0, KBSR[15]=1. A new key while ready is already set overwrites KBDR (no overrun flag).
- Read of KBDR: returns KBDR and clears KBSR[15]. If KeyValid arrives at the same edge, the read returns the old KBDR; the new character loads and KBSR[15] stays 1.
- DSR:
  - Bit 15 = ~DispValid.
  - Other bits read as 0.
  - Writes are ignored.
- Write to DDR:
  - If DSR[15]=1: DispData=MDR[7:0] and DispValid=1 from the next cycle until a cycle with DispReady=1, which clears DispValid on that edge.
  - If DSR[15]=0: the write is dropped. The access still completes with normal latency.
- DDR reads return {8'h00, DispData}.

Test Plan:
- SRAM write then read (WAIT_STATES=2):
  - Write: MAR=x3000, MDR=xBEEF, R_W=1 -> WE_N low for 2 cycles, R at T+3.
  - Read back from x3000 with R_W=0 -> In=xBEEF when R=1, OE_N low for 2 cycles.
- Keyboard:
  - KeyValid with KeyData=x41 -> read KBSR = x8000, read KBDR = x0041, then KBSR = x0000.
  - Write KBSR=x4000 plus a key -> KbdIntReq=1.
- Display with DispReady held 0:
  - Write DDR=x0048 -> DispValid=1, DSR=x0000.
  - Second DDR write x0049 -> DispData stays x48.
  - Raise DispReady -> DispValid=0 next edge, DSR=x8000.
- Simultaneous events: read KBDR in the same cycle as KeyValid (x42) with old KBDR=x41 -> In=x0041, KBSR stays x8000, KBDR=x0042.
- Unmapped/back-to-back:
  - Read xFE08 -> In=x0000 at T+1.
  - MIO_EN held high through DONE -> exactly one R pulse per access; the next access starts from IDLE.
- Reset mid-access: assert Reset during SRAM_ACC of a write -> strobes go high immediately, R never pulses, and the first access after release completes normally.

Source files
------------

// File: rtl/memory_io_controller.sv
// Memory / I-O stage for the eLC-3 datapath.
// Serves MAR/MDR requests from either external asynchronous SRAM (multi-cycle,
// WAIT_STATES strobe cycles) or the memory-mapped keyboard/display registers
// (single-cycle). Completion is signalled by a one-cycle R pulse.
module memory_io_controller #(
    parameter int WAIT_STATES = 2,
    parameter int SRAM_AW     = 20
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic [15:0]        i_MAR,
    input  logic [15:0]        i_MDR,
    input  logic               i_MIO_EN,
    input  logic               i_R_W,
    output logic [15:0]        o_In,
    output logic               o_R,
    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    output logic [15:0]        o_SRAM_WDATA,
    input  logic [15:0]        i_SRAM_RDATA,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_WE_N,
    input  logic               i_KeyValid,
    input  logic [7:0]         i_KeyData,
    output logic [7:0]         o_DispData,
    output logic               o_DispValid,
    input  logic               i_DispReady,
    output logic               o_KbdIntReq
);

    typedef enum logic [1:0] {IDLE, SRAM_ACC, DONE} state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_rw;
    logic [15:0]        r_in;
    logic               r_r;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [15:0]        r_sram_wdata;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_kb_ready;
    logic               r_kb_ie;
    logic [7:0]         r_kbdr;
    logic [7:0]         r_disp_data;
    logic               r_disp_valid;

    // The whole xFE00..xFFFF page belongs to devices; only four addresses are mapped.
    logic        w_start;
    logic        w_is_dev;
    logic        w_sel_kbsr;
    logic        w_sel_kbdr;
    logic        w_sel_dsr;
    logic        w_sel_ddr;
    logic        w_kbdr_rd;
    logic        w_kbsr_wr;
    logic        w_ddr_wr;
    logic [15:0] w_dev_rdata;

    assign w_start    = (r_state == IDLE) && i_MIO_EN;
    assign w_is_dev   = (i_MAR[15:9] == 7'h7F);
    assign w_sel_kbsr = (i_MAR == 16'hFE00);
    assign w_sel_kbdr = (i_MAR == 16'hFE02);
    assign w_sel_dsr  = (i_MAR == 16'hFE04);
    assign w_sel_ddr  = (i_MAR == 16'hFE06);
    assign w_kbdr_rd  = w_start && w_sel_kbdr && !i_R_W;
    assign w_kbsr_wr  = w_start && w_sel_kbsr && i_R_W;
    assign w_ddr_wr   = w_start && w_sel_ddr && i_R_W;

    // Device register read mux; unmapped device addresses read as zero.
    always_comb begin
        w_dev_rdata = 16'h0000;
        if (w_sel_kbsr)
            w_dev_rdata = {r_kb_ready, r_kb_ie, 14'b0};
        else if (w_sel_kbdr)
            w_dev_rdata = {8'h00, r_kbdr};
        else if (w_sel_dsr)
            w_dev_rdata = {~r_disp_valid, 15'b0};
        else if (w_sel_ddr)
            w_dev_rdata = {8'h00, r_disp_data};
    end

    // Access FSM: sequences SRAM strobes, captures read data, pulses R.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_rw         <= 1'b0;
            r_in         <= 16'h0000;
            r_r          <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= 16'h0000;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_r <= 1'b0;
                    if (w_start) begin
                        r_rw <= i_R_W;
                        if (w_is_dev) begin
                            if (!i_R_W)
                                r_in <= w_dev_rdata;
                            r_r     <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_sram_addr <= {{(SRAM_AW-16){1'b0}}, i_MAR};
                            r_ce_n      <= 1'b0;
                            if (i_R_W) begin
                                r_we_n       <= 1'b0;
                                r_sram_wdata <= i_MDR;
                            end else begin
                                r_oe_n <= 1'b0;
                            end
                            r_cnt   <= 4'(WAIT_STATES - 1);
                            r_state <= SRAM_ACC;
                        end
                    end
                end
                SRAM_ACC: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_rw)
                            r_in <= i_SRAM_RDATA;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_r     <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    // A request still held high here belongs to the access just finished.
                    r_r     <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Keyboard and display registers; a new key wins over the KBDR read-clear.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_kb_ready   <= 1'b0;
            r_kb_ie      <= 1'b0;
            r_kbdr       <= 8'h00;
            r_disp_data  <= 8'h00;
            r_disp_valid <= 1'b0;
        end else begin
            if (i_KeyValid) begin
                r_kbdr     <= i_KeyData;
                r_kb_ready <= 1'b1;
            end else if (w_kbdr_rd) begin
                r_kb_ready <= 1'b0;
            end
            if (w_kbsr_wr)
                r_kb_ie <= i_MDR[14];
            // A DDR write is only taken while the display is idle (DSR ready).
            if (w_ddr_wr && !r_disp_valid) begin
                r_disp_data  <= i_MDR[7:0];
                r_disp_valid <= 1'b1;
            end else if (r_disp_valid && i_DispReady) begin
                r_disp_valid <= 1'b0;
            end
        end
    end

    assign o_In         = r_in;
    assign o_R          = r_r;
    assign o_SRAM_ADDR  = r_sram_addr;
    assign o_SRAM_WDATA = r_sram_wdata;
    assign o_SRAM_CE_N  = r_ce_n;
    assign o_SRAM_OE_N  = r_oe_n;
    assign o_SRAM_WE_N  = r_we_n;
    assign o_DispData   = r_disp_data;
    assign o_DispValid  = r_disp_valid;
    assign o_KbdIntReq  = r_kb_ready & r_kb_ie;

endmodule

// File: tb/tb_memory_io_controller.sv
// Directed bench for memory_io_controller: each access pushes the expected
// In value onto a scoreboard queue, popped and compared when R pulses.
module tb_memory_io_controller;

    localparam int WS = 2;
    localparam int AW = 20;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [15:0]   MAR, MDR;
    logic          MIO_EN, R_W;
    logic [15:0]   In;
    logic          R;
    logic [AW-1:0] SRAM_ADDR;
    logic [15:0]   SRAM_WDATA, SRAM_RDATA;
    logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
    logic          KeyValid;
    logic [7:0]    KeyData;
    logic [7:0]    DispData;
    logic          DispValid, DispReady, KbdIntReq;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_in = 16'h0000;
    logic [15:0] mem [0:255];

    memory_io_controller #(.WAIT_STATES(WS), .SRAM_AW(AW)) dut (
        .i_Clk(Clk), .i_Reset(Reset), .i_MAR(MAR), .i_MDR(MDR),
        .i_MIO_EN(MIO_EN), .i_R_W(R_W), .o_In(In), .o_R(R),
        .o_SRAM_ADDR(SRAM_ADDR), .o_SRAM_WDATA(SRAM_WDATA), .i_SRAM_RDATA(SRAM_RDATA),
        .o_SRAM_CE_N(SRAM_CE_N), .o_SRAM_OE_N(SRAM_OE_N), .o_SRAM_WE_N(SRAM_WE_N),
        .i_KeyValid(KeyValid), .i_KeyData(KeyData), .o_DispData(DispData),
        .o_DispValid(DispValid), .i_DispReady(DispReady), .o_KbdIntReq(KbdIntReq)
    );

    always #5 Clk = ~Clk;

    // Simple SRAM model: write while CE/WE low at a clock edge, async read while CE/OE low.
    always @(posedge Clk)
        if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_WDATA;
    assign SRAM_RDATA = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access. Called just after a rising edge. rexp is the read value
    // expected (ignored for writes). Latency and strobe cycles come from the
    // address: device page = 1 cycle, SRAM = 1+WS cycles.
    task automatic acc(input string tag, input logic [15:0] a, input logic [15:0] d,
                       input logic w, input logic [15:0] rexp, input logic hold,
                       input logic kv, input logic [7:0] kd);
        int n, we_c, oe_c, lat;
        logic is_sram;
        is_sram = (a < 16'hFE00);
        lat = is_sram ? 1 + WS : 1;
        if (!w) last_in = rexp;
        exp_q.push_back(last_in);
        MAR = a; MDR = d; R_W = w; MIO_EN = 1'b1; KeyValid = kv; KeyData = kd;
        @(posedge Clk); #1;
        KeyValid = 1'b0;
        if (!hold) MIO_EN = 1'b0;
        n = 1; we_c = 0; oe_c = 0;
        if (is_sram) begin
            chk({tag, "_addr"}, 32'(SRAM_ADDR), 32'(a));
            if (w) chk({tag, "_wdata"}, 32'(SRAM_WDATA), 32'(d));
        end
        while (R !== 1'b1 && n < 40) begin
            if (!SRAM_WE_N) we_c++;
            if (!SRAM_OE_N) oe_c++;
            @(posedge Clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_we_cyc"}, 32'(we_c), 32'((is_sram && w) ? WS : 0));
        chk({tag, "_oe_cyc"}, 32'(oe_c), 32'((is_sram && !w) ? WS : 0));
        chk({tag, "_in"}, 32'(In), 32'(exp_q.pop_front()));
        @(posedge Clk); #1;
        chk({tag, "_rpulse"}, 32'(R), 32'(0));
        if (hold) chk({tag, "_noretrig"}, 32'(SRAM_CE_N), 32'(1));
        MIO_EN = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] rexp);
        acc(tag, a, 16'h0000, 1'b0, rexp, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d);
        acc(tag, a, d, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic key(input logic [7:0] kd);
        KeyValid = 1'b1; KeyData = kd;
        @(posedge Clk); #1;
        KeyValid = 1'b0;
    endtask

    initial begin
        int rbad;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        Reset = 1'b0; MAR = 16'h0; MDR = 16'h0; MIO_EN = 1'b0; R_W = 1'b0;
        KeyValid = 1'b0; KeyData = 8'h00; DispReady = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("rst_in", 32'(In), 32'(0));
        chk("rst_r", 32'(R), 32'(0));
        chk("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}), 32'(3'b111));
        chk("rst_addr", 32'(SRAM_ADDR), 32'(0));
        chk("rst_wdata", 32'(SRAM_WDATA), 32'(0));
        chk("rst_dispvalid", 32'(DispValid), 32'(0));
        chk("rst_dispdata", 32'(DispData), 32'(0));
        chk("rst_kbdint", 32'(KbdIntReq), 32'(0));
        Reset = 1'b1;
        @(posedge Clk); #1;

        // SRAM write then read back
        wr("sram_wr", 16'h3000, 16'hBEEF);
        rd("sram_rd", 16'h3000, 16'hBEEF);

        // Keyboard basic
        rd("kbsr_idle", 16'hFE00, 16'h0000);
        key(8'h41);
        rd("kbsr_ready", 16'hFE00, 16'h8000);
        rd("kbdr_41", 16'hFE02, 16'h0041);
        rd("kbsr_clr", 16'hFE00, 16'h0000);

        // KBDR read coinciding with a new key: old data returned, ready stays set
        acc("kbdr_race", 16'hFE02, 16'h0000, 1'b0, 16'h0041, 1'b0, 1'b1, 8'h42);
        rd("kbsr_race", 16'hFE00, 16'h8000);
        rd("kbdr_42", 16'hFE02, 16'h0042);
        rd("kbsr_clr2", 16'hFE00, 16'h0000);

        // Interrupt request
        wr("kbsr_ie", 16'hFE00, 16'h4000);
        chk("kbdint_noready", 32'(KbdIntReq), 32'(0));
        key(8'h43);
        chk("kbdint_set", 32'(KbdIntReq), 32'(1));
        rd("kbsr_c000", 16'hFE00, 16'hC000);
        wr("kbsr_ie_off", 16'hFE00, 16'hBFFF);
        chk("kbdint_off", 32'(KbdIntReq), 32'(0));

        // Display with DispReady held low
        rd("dsr_ready", 16'hFE04, 16'h8000);
        wr("ddr_48", 16'hFE06, 16'h0048);
        chk("disp_valid", 32'(DispValid), 32'(1));
        chk("disp_data48", 32'(DispData), 32'(8'h48));
        rd("dsr_busy", 16'hFE04, 16'h0000);
        wr("ddr_49_drop", 16'hFE06, 16'h0049);
        chk("disp_data_kept", 32'(DispData), 32'(8'h48));
        rd("ddr_rd", 16'hFE06, 16'h0048);
        DispReady = 1'b1;
        @(posedge Clk); #1;
        chk("disp_cleared", 32'(DispValid), 32'(0));
        DispReady = 1'b0;
        rd("dsr_ready2", 16'hFE04, 16'h8000);
        wr("ddr_4a", 16'hFE06, 16'h004A);
        chk("disp_data4a", 32'(DispData), 32'(8'h4A));
        DispReady = 1'b1;
        @(posedge Clk); #1;
        DispReady = 1'b0;

        // Unmapped device addresses
        wr("unmapped_wr", 16'hFE0A, 16'hFFFF);
        rd("unmapped_rd", 16'hFE08, 16'h0000);
        rd("sram_rd2", 16'h3000, 16'hBEEF);
        rd("unmapped_top", 16'hFFFE, 16'h0000);

        // MIO_EN held through DONE, then an immediate fresh access
        acc("hold_rd", 16'h3000, 16'h0000, 1'b0, 16'hBEEF, 1'b1, 1'b0, 8'h00);
        acc("hold_dev", 16'hFE04, 16'h0000, 1'b0, 16'h8000, 1'b1, 1'b0, 8'h00);
        wr("after_hold", 16'h3008, 16'h1357);
        rd("after_hold_rd", 16'h3008, 16'h1357);

        // Reset during an SRAM write
        MAR = 16'h3010; MDR = 16'h1234; R_W = 1'b1; MIO_EN = 1'b1;
        @(posedge Clk); #1;
        MIO_EN = 1'b0;
        chk("mid_we_low", 32'(SRAM_WE_N), 32'(0));
        Reset = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}), 32'(3'b111));
        chk("mid_rst_in", 32'(In), 32'(0));
        rbad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            if (R !== 1'b0) rbad++;
        end
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (R !== 1'b0) rbad++;
        end
        chk("mid_rst_no_r", 32'(rbad), 32'(0));
        last_in = 16'h0000;
        wr("post_rst_wr", 16'h3020, 16'hA5A5);
        rd("post_rst_rd", 16'h3020, 16'hA5A5);
        rd("post_rst_dsr", 16'hFE04, 16'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
